// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: state enum,
// ALU operation codes, datapath mux selects and the supported opcodes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_RD    = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WR    = 4'd8,
        S_BRANCH    = 4'd9,
        S_EXEC_JALR = 4'd10,
        S_JUMP_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;

    function automatic logic [2:0] alu_rtype(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b100:  return ALU_XOR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// DECODE dispatch: maps opcode/funct3 of the latched instruction to the
// first execution state; anything outside the supported subset is ILLEGAL.
module multicycle_next_state
    import multicycle_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    output state_t     next_o
);

    always_comb begin
        next_o = S_ILLEGAL;
        case (op_i)
            OP_R:      if (funct3_i inside {3'b000, 3'b001, 3'b100, 3'b111}) next_o = S_EXEC_R;
            OP_IMM:    if (funct3_i == 3'b000) next_o = S_EXEC_I;
            OP_LOAD,
            OP_STORE:  if (funct3_i == 3'b010) next_o = S_MEM_ADDR;
            OP_BRANCH: if (funct3_i inside {3'b000, 3'b001}) next_o = S_BRANCH;
            OP_JAL:    next_o = S_JUMP_WB;
            OP_JALR:   next_o = S_EXEC_JALR;
            default:   next_o = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM with a shared memory port. Defining
// MULTICYCLE_ILLEGAL_TRAP_EN makes ILLEGAL a sticky halt and adds the Illegal port.
module multicycle_ctrl_fsm
    import multicycle_pkg::*;
#(
    parameter int unsigned RESET_STATE_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       RegWrite,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic       Illegal,
`endif
    output logic       Retire
);

    localparam logic [1:0] HOLD_INIT = 2'(RESET_STATE_HOLD);

    state_t     state_q;
    state_t     dispatch;
    logic [1:0] hold_q;
    logic       unused_funct7;

    // No supported instruction distinguishes on bit 30 (SUB/SRA are not in the subset).
    assign unused_funct7 = funct7;

    multicycle_next_state u_next_state (
        .op_i     (op),
        .funct3_i (funct3),
        .next_o   (dispatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            hold_q  <= HOLD_INIT;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (hold_q != 2'd0)
                        hold_q <= hold_q - 2'd1;
                    else if (MemReady)
                        state_q <= S_DECODE;
                end
                S_DECODE:    state_q <= dispatch;
                S_EXEC_R,
                S_EXEC_I:    state_q <= S_ALU_WB;
                S_MEM_ADDR:  state_q <= (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:    if (MemReady) state_q <= S_MEM_WB;
                S_MEM_WR:    if (MemReady) state_q <= S_FETCH;
                S_EXEC_JALR: state_q <= S_JUMP_WB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                S_ILLEGAL:   state_q <= S_ILLEGAL;
`else
                S_ILLEGAL:   state_q <= S_FETCH;
`endif
                // Final single-cycle states and unused encodings all return to FETCH.
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b0;
        Retire     = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        Illegal    = 1'b0;
`endif
        // Reset masks every output so an aborted instruction leaves no side effects.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if (hold_q == 2'd0) begin
                        MemReq  = 1'b1;
                        ALUSrcB = SRCB_FOUR;
                        IRWrite = MemReady;
                        PCWrite = MemReady;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_EXEC_R: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUControl = alu_rtype(funct3);
                end
                S_EXEC_I,
                S_EXEC_JALR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    Retire   = 1'b1;
                end
                S_MEM_RD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEM_WB: begin
                    ResultSrc = RES_MEM;
                    RegWrite  = 1'b1;
                    Retire    = 1'b1;
                end
                S_MEM_WR: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    Retire   = MemReady;
                end
                S_BRANCH: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUControl = ALU_SUB;
                    PCSrc      = 1'b1;
                    PCWrite    = (funct3 == 3'b000) ? Zero : ~Zero;
                    Retire     = 1'b1;
                end
                S_JUMP_WB: begin
                    ResultSrc = RES_PC;
                    RegWrite  = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = 1'b1;
                    Retire    = 1'b1;
                end
                S_ILLEGAL: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    Illegal = 1'b1;
`else
                    Retire  = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Random instruction stream against a per-instruction summary model; a monitor
// tallies DUT activity between Retire pulses and compares against a scoreboard.
module tb_multicycle_ctrl_fsm;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7 = 1'b0, Zero = 1'b0, MemReady = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, Retire;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [2:0] ALUControl;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       Illegal;
    wire        ill_w = Illegal;
    localparam int MAXK = 7;
`else
    wire        ill_w = 1'b0;
    localparam int MAXK = 8;
`endif

    wire [19:0] all_o = {ill_w, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, ALUSrcA,
                         ALUSrcB, ALUControl, ImmSrc, ResultSrc, RegWrite, Retire};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.RESET_STATE_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .RegWrite(RegWrite),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .Illegal(Illegal),
`endif
        .Retire(Retire)
    );

    typedef struct {
        string name;
        int cyc, rw, rsrc, pcw, pcs1, both, mreq, mwr, adr1, dsig, xsig;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sig(input int a, input int b, input int i, input int c);
        return a * 128 + b * 32 + i * 8 + c;
    endfunction

    // Per-instruction summary derived from the instruction-class rules.
    function automatic exp_t model(input int k, input logic [6:0] o, input logic [2:0] f3,
                                   input bit z, input int fw, input int mw);
        exp_t e;
        int   taken;
        e = '{name: "", cyc: 0, rw: 0, rsrc: 0, pcw: 1, pcs1: 0, both: 0, mreq: fw + 1,
              mwr: 0, adr1: 0, dsig: 0, xsig: 0};
        e.dsig = sig(1, 1, (o == 7'd111) ? 3 : 2, 0);
        case (k)
            0: begin e.name = "R";    e.cyc = 4; e.rw = 1; e.xsig = sig(2, 0, 0, int'(f3)); end
            1: begin e.name = "ADDI"; e.cyc = 4; e.rw = 1; e.xsig = sig(2, 1, 0, 0); end
            2: begin
                e.name = "LW"; e.cyc = 5 + mw; e.rw = 1; e.rsrc = 1;
                e.mreq += mw + 1; e.adr1 = mw + 1; e.xsig = sig(2, 1, 0, 0);
            end
            3: begin
                e.name = "SW"; e.cyc = 4 + mw; e.mreq += mw + 1; e.mwr = mw + 1;
                e.adr1 = mw + 1; e.xsig = sig(2, 1, 1, 0);
            end
            4, 5: begin
                e.name = (k == 4) ? "BEQ" : "BNE"; e.cyc = 3;
                taken = (k == 4) ? int'(z) : int'(!z);
                e.pcw += taken; e.pcs1 = taken; e.xsig = sig(2, 0, 0, 2);
            end
            6, 7: begin
                e.name = (k == 6) ? "JAL" : "JALR"; e.cyc = (k == 6) ? 3 : 4;
                e.rw = 1; e.rsrc = 2; e.pcw = 2; e.pcs1 = 1; e.both = 1;
                e.xsig = (k == 6) ? 0 : sig(2, 1, 0, 0);
            end
            default: begin e.name = "ILL"; e.cyc = 3; end
        endcase
        e.cyc += fw;
        return e;
    endfunction

    // Monitor: accumulate activity, compare at each Retire.
    initial begin
        int   cyc, rw, rsrc, pcw, pcs1, both, mreq, mwr, adr1, dsig, xsig, irw_at, s;
        exp_t e;
        cyc = 0; rw = 0; rsrc = 0; pcw = 0; pcs1 = 0; both = 0; mreq = 0; mwr = 0;
        adr1 = 0; dsig = 0; xsig = 0; irw_at = -10;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                cyc = 0; rw = 0; rsrc = 0; pcw = 0; pcs1 = 0; both = 0; mreq = 0; mwr = 0;
                adr1 = 0; dsig = 0; xsig = 0; irw_at = -10;
            end else begin
                cyc++;
                s = sig(int'(ALUSrcA), int'(ALUSrcB), int'(ImmSrc), int'(ALUControl));
                if (IRWrite) begin
                    irw_at = cyc;
                    chk("fetch_sig", int'({ALUSrcA, ALUSrcB, ALUControl, AdrSrc, PCSrc}),
                        int'(11'b00_10_000_0_0));
                end
                if (cyc == irw_at + 1) dsig = s;
                if (cyc == irw_at + 2) xsig = s;
                rw   += int'(RegWrite);
                if (RegWrite) rsrc |= int'(ResultSrc);
                pcw  += int'(PCWrite);
                pcs1 += int'(PCWrite & PCSrc);
                both += int'(RegWrite & PCWrite);
                mreq += int'(MemReq);
                mwr  += int'(MemWrite);
                adr1 += int'(MemReq & AdrSrc);
                if (Retire || cyc > 60) begin
                    if (!Retire) chk("retire_timeout", cyc, 0);
                    else if (sb.size() == 0) chk("retire_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk({e.name, " cycles"}, cyc, e.cyc);
                        chk({e.name, " regwrite"}, rw, e.rw);
                        chk({e.name, " resultsrc"}, rsrc, e.rsrc);
                        chk({e.name, " pcwrite"}, pcw, e.pcw);
                        chk({e.name, " pcsrc1"}, pcs1, e.pcs1);
                        chk({e.name, " rw_pcw_same"}, both, e.both);
                        chk({e.name, " memreq"}, mreq, e.mreq);
                        chk({e.name, " memwrite"}, mwr, e.mwr);
                        chk({e.name, " adrsrc"}, adr1, e.adr1);
                        chk({e.name, " decode_sig"}, dsig, e.dsig);
                        chk({e.name, " exec_sig"}, xsig, e.xsig);
                    end
                    cyc = 0; rw = 0; rsrc = 0; pcw = 0; pcs1 = 0; both = 0; mreq = 0;
                    mwr = 0; adr1 = 0; dsig = 0; xsig = 0; irw_at = -10;
                end
            end
        end
    end

    // Driver: issue instructions, run the memory handshake on the model's timeline.
    initial begin
        int         k, fw, mw, len, j, ill_cnt;
        logic [6:0] o;
        logic [2:0] f3;
        bit         z, is_mem;
        exp_t       e;
        logic [2:0] rf3 [4] = '{3'b000, 3'b001, 3'b100, 3'b111};
        logic [2:0] bf3 [4] = '{3'b010, 3'b011, 3'b101, 3'b110};

        repeat (3) @(negedge clk);
        #2 chk("reset_outs", int'(all_o), 0);
        @(negedge clk);
        rst = 1'b0; MemReady = 1'b1; mon_en = 1'b1;
        repeat (HOLD - 1) begin @(negedge clk); MemReady = 1'($urandom_range(0, 1)); end

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, MAXK);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            z  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom);
            case (k)
                0: begin o = 7'd51; f3 = rf3[$urandom_range(0, 3)]; end
                1: begin o = 7'd19; f3 = 3'd0; end
                2: begin o = 7'd3;  f3 = 3'd2; end
                3: begin o = 7'd35; f3 = 3'd2; end
                4: begin o = 7'd99; f3 = 3'd0; end
                5: begin o = 7'd99; f3 = 3'd1; end
                6: o = 7'd111;
                7: o = 7'd103;
                default: begin
                    j = $urandom_range(0, 3);
                    if (j == 0) o = 7'h7F;
                    else if (j == 1) begin o = 7'd51; f3 = bf3[$urandom_range(0, 3)]; end
                    else if (j == 2) begin o = 7'd99; f3 = 3'($urandom_range(2, 7)); end
                    else begin o = 7'd19; f3 = 3'($urandom_range(1, 7)); end
                end
            endcase
            e   = model(k, o, f3, z, fw, mw);
            len = e.cyc;
            if (n == 0) e.cyc += HOLD;
            sb.push_back(e);
            is_mem = (k == 2 || k == 3);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (c < fw) begin
                    op = 7'($urandom); funct3 = 3'($urandom); MemReady = 1'b0;
                end else if (c == fw) begin
                    op = o; funct3 = f3; Zero = z; funct7 = 1'($urandom); MemReady = 1'b1;
                end else if (is_mem && c >= fw + 3 && c <= fw + 3 + mw)
                    MemReady = (c == fw + 3 + mw);
                else
                    MemReady = 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        MemReady = 1'b0; mon_en = 1'b0;
        #3 chk("sb_drain", sb.size(), 0);

        // Abort a store mid-access with reset, then check the hold window.
        op = 7'd35; funct3 = 3'd2;
        @(negedge clk); MemReady = 1'b1;
        @(negedge clk); MemReady = 1'b0;
        @(negedge clk);
        @(negedge clk); #2 chk("sw_memreq_memwrite", int'({MemReq, MemWrite, AdrSrc}), 7);
        @(negedge clk); #2 chk("sw_stall_held", int'({MemReq, MemWrite, Retire}), 6);
        @(negedge clk); rst = 1'b1; MemReady = 1'b1;
        #2 chk("rst_cycle_outs", int'(all_o), 0);
        @(negedge clk); rst = 1'b0;
        #2 chk("post_rst_outs", int'(all_o), 0);
        @(negedge clk); #2 chk("hold1_memreq", int'(MemReq), 0);
        @(negedge clk); op = 7'h7F;
        #2 chk("hold_done_memreq", int'(MemReq), 1);
        chk("fetch_illegal_low", int'(ill_w), 0);
        @(negedge clk); MemReady = 1'b0;
        @(negedge clk);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        #2 chk("illegal_set", int'(Illegal), 1);
        ill_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); MemReady = 1'($urandom_range(0, 1));
            #2 if (Illegal && !MemReq) ill_cnt++;
        end
        chk("illegal_sticky_10", ill_cnt, 10);
`else
        ill_cnt = 0;
        #2 chk("illegal_nop_outs", int'(all_o), 1);
        @(negedge clk);
        #2 chk("illegal_refetch", int'(MemReq), 1);
        chk("illegal_cnt", ill_cnt, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
